// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one synchronous lookup ROM between NREQ requesters.
// Each grant runs IDLE -> READ -> DONE, returning the ROM word with a one-cycle rvalid pulse.
module rom_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 5,
  parameter int DW   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
  output logic [NREQ-1:0]    gnt,
  output logic [DW-1:0]      rdata,
  output logic [NREQ-1:0]    rvalid,
  output logic               busy,
  output logic [AW-1:0]      rom_addr,
  input  logic [DW-1:0]      rom_data
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [IW-1:0]     r_last;
  logic [NREQ-1:0]   r_gnt;
  logic [NREQ-1:0]   r_rvalid;
  logic [DW-1:0]     r_rdata;
  logic [AW-1:0]     r_rom_addr;
  logic              r_busy;

  logic              w_any;
  logic [IW-1:0]     w_winner;
  logic [IW:0]       w_idx;

  // Search starts one past the last winner and wraps; first set request wins.
  always_comb begin
    w_any    = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = {1'b0, r_last} + (IW+1)'(k);
      if (w_idx >= (IW+1)'(NREQ)) w_idx = w_idx - (IW+1)'(NREQ);
      if (!w_any && req[w_idx[IW-1:0]]) begin
        w_any    = 1'b1;
        w_winner = w_idx[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_last     <= IW'(NREQ - 1);
      r_gnt      <= '0;
      r_rvalid   <= '0;
      r_rdata    <= '0;
      r_rom_addr <= '0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rvalid <= '0;
          if (w_any) begin
            r_gnt      <= {{(NREQ-1){1'b0}}, 1'b1} << w_winner;
            r_rom_addr <= req_addr[w_winner*AW +: AW];
            r_last     <= w_winner;
            r_busy     <= 1'b1;
            r_state    <= S_READ;
          end
        end
        S_READ: begin
          // ROM output settled on the falling edge after rom_addr was driven.
          r_rdata  <= rom_data;
          r_rvalid <= r_gnt;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          r_rvalid <= '0;
          r_gnt    <= '0;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_rvalid <= '0;
          r_gnt    <= '0;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt      = r_gnt;
  assign rdata    = r_rdata;
  assign rvalid   = r_rvalid;
  assign busy     = r_busy;
  assign rom_addr = r_rom_addr;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter with a falling-edge ROM model where ROM[a] = a[3:0].
module tb_rom_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 5;
  localparam int DW   = 4;

  logic               clk;
  logic               rst;
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]    gnt;
  logic [DW-1:0]      rdata;
  logic [NREQ-1:0]    rvalid;
  logic               busy;
  logic [AW-1:0]      rom_addr;
  logic [DW-1:0]      rom_data;

  int n_chk;
  int n_fail;

  rom_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_addr (req_addr),
    .gnt      (gnt),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .busy     (busy),
    .rom_addr (rom_addr),
    .rom_data (rom_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) rom_data <= rom_addr[3:0];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  task automatic do_reset();
    req = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One full transaction for requester i; req[i] dropped on rvalid unless keep is set.
  task automatic serve(input string tag, input int i, input int addr, input int data, input bit keep);
    tick();
    check({tag, "_gnt"}, 32'(gnt), 32'(1 << i));
    check({tag, "_addr"}, 32'(rom_addr), 32'(addr));
    check({tag, "_busy1"}, 32'(busy), 1);
    check({tag, "_rv0"}, 32'(rvalid), 0);
    tick();
    check({tag, "_rvalid"}, 32'(rvalid), 32'(1 << i));
    check({tag, "_rdata"}, 32'(rdata), 32'(data));
    check({tag, "_busy2"}, 32'(busy), 1);
    if (!keep) req[i] = 1'b0;
    tick();
    check({tag, "_rvend"}, 32'(rvalid), 0);
    check({tag, "_gntend"}, 32'(gnt), 0);
    check({tag, "_busyend"}, 32'(busy), 0);
    check({tag, "_hold"}, 32'(rdata), 32'(data));
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    rst      = 1'b1;
    req      = '0;
    req_addr = '0;
    tick();
    tick();
    check("rst_gnt", 32'(gnt), 0);
    check("rst_rvalid", 32'(rvalid), 0);
    check("rst_rdata", 32'(rdata), 0);
    check("rst_romaddr", 32'(rom_addr), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 0);

    // Single request
    set_addr(0, 5);
    req = 4'b0001;
    serve("single", 0, 5, 5, 1'b0);
    tick();
    check("single_idle", 32'(gnt), 0);

    // Simultaneous requests from a fresh reset: rotation 0,1,2,3
    do_reset();
    set_addr(0, 3);
    set_addr(1, 7);
    set_addr(2, 19);
    set_addr(3, 30);
    req = 4'b1111;
    serve("sim0", 0, 3, 3, 1'b0);
    serve("sim1", 1, 7, 7, 1'b0);
    serve("sim2", 2, 19, 3, 1'b0);
    serve("sim3", 3, 30, 14, 1'b0);
    tick();
    check("sim_idle", 32'(busy), 0);

    // Fairness: 0 and 2 held permanently
    do_reset();
    set_addr(0, 4);
    set_addr(2, 11);
    req = 4'b0101;
    serve("fair0a", 0, 4, 4, 1'b1);
    serve("fair2a", 2, 11, 11, 1'b1);
    serve("fair0b", 0, 4, 4, 1'b1);
    serve("fair2b", 2, 11, 11, 1'b1);
    req = '0;
    tick();
    check("fair_idle", 32'(gnt), 0);

    // Dropped request during READ still completes; late address change ignored
    set_addr(1, 13);
    req = 4'b0010;
    tick();
    check("drop_gnt", 32'(gnt), 2);
    check("drop_addr", 32'(rom_addr), 13);
    req = '0;
    set_addr(1, 1);
    tick();
    check("drop_rvalid", 32'(rvalid), 2);
    check("drop_rdata", 32'(rdata), 13);
    tick();
    check("drop_rvend", 32'(rvalid), 0);
    check("drop_gntend", 32'(gnt), 0);
    tick();
    check("drop_idle", 32'(busy), 0);

    // Reset mid-READ
    set_addr(2, 6);
    req = 4'b0100;
    tick();
    check("mid_gnt", 32'(gnt), 4);
    rst = 1'b1;
    #1;
    check("mid_gnt0", 32'(gnt), 0);
    check("mid_busy0", 32'(busy), 0);
    check("mid_addr0", 32'(rom_addr), 0);
    req = '0;
    tick();
    check("mid_rvalid0", 32'(rvalid), 0);
    check("mid_rdata0", 32'(rdata), 0);
    rst = 1'b0;
    tick();
    check("mid_norv", 32'(rvalid), 0);
    set_addr(3, 21);
    req = 4'b1000;
    serve("post3", 3, 21, 5, 1'b0);
    set_addr(0, 8);
    req = 4'b1001;
    serve("tie0", 0, 8, 8, 1'b0);
    serve("tie3", 3, 21, 5, 1'b0);

    // Back-to-back same requester with a new address between reads
    do_reset();
    set_addr(0, 2);
    req = 4'b0001;
    tick();
    check("b2b_gnt1", 32'(gnt), 1);
    check("b2b_addr1", 32'(rom_addr), 2);
    tick();
    check("b2b_rv1", 32'(rvalid), 1);
    check("b2b_rd1", 32'(rdata), 2);
    set_addr(0, 9);
    tick();
    check("b2b_gap", 32'(gnt), 0);
    serve("b2b2", 0, 9, 9, 1'b0);
    tick();
    check("b2b_idle", 32'(gnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
